// File: rtl/mul_div_unit.sv
// Iterative 32x32 multiply / divide unit with architectural HI/LO registers.
// Latency: MULT/MULTU/MADD/MSUB/DIV/DIVU 33 cycles of Busy, then Done; MTHI/MTLO/div-by-zero complete in 1 cycle.
// Backpressure: Start is sampled only in IDLE; a Start while Busy is dropped, never queued.
//
// Ports:
//   Clk, Reset      rising-edge clock, asynchronous active-low reset
//   Start, Op       request strobe and 4-bit operation code
//   A, B            rs / rt operands, latched on an accepted Start
//   Busy            high while an iterative operation is in flight (state != IDLE)
//   Done            one-cycle pulse; Hi/Lo already hold the new values
//   DivByZero       sticky flag from the last accepted request (set by DIV/DIVU with B == 0)
//   Hi, Lo          architectural HI / LO registers
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [3:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_MULT  = 4'h1;
  localparam logic [3:0] OP_MULTU = 4'h2;
  localparam logic [3:0] OP_DIV   = 4'h3;
  localparam logic [3:0] OP_DIVU  = 4'h4;
  localparam logic [3:0] OP_MTHI  = 4'h5;
  localparam logic [3:0] OP_MTLO  = 4'h6;
  localparam logic [3:0] OP_MADD  = 4'h7;
  localparam logic [3:0] OP_MSUB  = 4'h8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_FIX  = 2'd3;

  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [3:0]         op_q, op_d;
  // Multiplicand magnitude for MUL, divisor magnitude for DIV.
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  // MUL: {partial product high, multiplier bits still to consume}.
  // DIV: {partial remainder, dividend bits shifting into quotient}.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_q, neg_d;    // product / quotient must be negated
  logic               rneg_q, rneg_d;  // remainder must be negated (dividend sign)
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  // Operand preparation for an accepted request.
  logic               op_signed;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;

  assign op_signed = (Op == OP_MULT) || (Op == OP_MADD) || (Op == OP_MSUB) || (Op == OP_DIV);
  assign a_neg     = op_signed & A[WIDTH-1];
  assign b_neg     = op_signed & B[WIDTH-1];
  assign a_mag     = a_neg ? (~A + 1'b1) : A;
  assign b_mag     = b_neg ? (~B + 1'b1) : B;

  // Shift-add step: add multiplicand into the upper half when the current
  // multiplier bit is set; the carry lands in the MSB after the right shift.
  logic [WIDTH:0]     mul_sum;
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};

  // Restoring step: the partial remainder is always below the divisor, so the
  // shifted-in value fits in WIDTH+1 bits and a borrow in bit WIDTH means "restore".
  logic [WIDTH:0]     div_trial;
  assign div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opnd_q};

  // Sign-corrected results used in FIX.
  logic [2*WIDTH-1:0] prod_signed;
  logic [2*WIDTH-1:0] hilo_madd;
  logic [2*WIDTH-1:0] hilo_msub;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign prod_signed = neg_q ? (~acc_q + 1'b1) : acc_q;
  assign hilo_madd   = {hi_q, lo_q} + prod_signed;
  assign hilo_msub   = {hi_q, lo_q} - prod_signed;
  assign quo_fix     = neg_q  ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
  assign rem_fix     = rneg_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          case (Op)
            OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
              op_d    = Op;
              opnd_d  = a_mag;
              acc_d   = {{WIDTH{1'b0}}, b_mag};
              neg_d   = a_neg ^ b_neg;
              cnt_d   = '0;
              dbz_d   = 1'b0;
              state_d = ST_MUL;
            end
            OP_DIV, OP_DIVU: begin
              if (B == '0) begin
                // Completes immediately, HI/LO untouched.
                dbz_d  = 1'b1;
                done_d = 1'b1;
              end else begin
                op_d    = Op;
                opnd_d  = b_mag;
                acc_d   = {{WIDTH{1'b0}}, a_mag};
                neg_d   = a_neg ^ b_neg;
                rneg_d  = a_neg;
                cnt_d   = '0;
                dbz_d   = 1'b0;
                state_d = ST_DIV;
              end
            end
            OP_MTHI: begin
              hi_d   = A;
              dbz_d  = 1'b0;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = A;
              dbz_d  = 1'b0;
              done_d = 1'b1;
            end
            default: begin
              // NOP and undefined codes are not accepted.
            end
          endcase
        end
      end

      ST_MUL: begin
        if (acc_q[0]) begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end else begin
          acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d = ST_FIX;
        end
      end

      ST_DIV: begin
        if (!div_trial[WIDTH]) begin
          acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d = ST_FIX;
        end
      end

      ST_FIX: begin
        case (op_q)
          OP_MADD: begin
            hi_d = hilo_madd[2*WIDTH-1:WIDTH];
            lo_d = hilo_madd[WIDTH-1:0];
          end
          OP_MSUB: begin
            hi_d = hilo_msub[2*WIDTH-1:WIDTH];
            lo_d = hilo_msub[WIDTH-1:0];
          end
          OP_DIV, OP_DIVU: begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
          default: begin
            hi_d = prod_signed[2*WIDTH-1:WIDTH];
            lo_d = prod_signed[WIDTH-1:0];
          end
        endcase
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign Busy      = (state_q != ST_IDLE);
  assign Done      = done_q;
  assign DivByZero = dbz_q;
  assign Hi        = hi_q;
  assign Lo        = lo_q;

endmodule
